snddma_ctrl: RTL
================

// Module: snddma_ctrl
// PURPOSE
//  Parametrised N-channel sound DMA controller; successor to the single-channel sound DMA control in the MCU.
//  Each channel walks a frame from start to end address, with optional frame repeat and a prefetch FIFO.
//  A frame-end interrupt is raised per channel. One fetch is issued per bus slot that the MCU grants to sound.
//  Sits between the MCU slot timing (clk32 enables) and the DAC/mixer.
// PARAMETERS
//  NCH    2   number of sound channels (1..4)
//  AW     21  word-address width, address bits [AW:1]
//  DW     16  bus data width
//  FDEPTH 4   per-channel FIFO depth in words (power of 2, >=2)
// PORTS
//  clk32     in   1        system clock; all state changes on its rising edge
//  porb      in   1        async active-low reset
//  slot_en   in   1        one-clk32 strobe marking a sound bus slot (as c1_en_p)
//  sndon     in   NCH      per-channel enable, sampled on slot_en
//  sfrep     in   NCH      per-channel frame-repeat mode
//  sfstart   in   NCH*AW   per-channel frame start address, ch0 in LSBs
//  sfend     in   NCH*AW   per-channel frame end address, inclusive
//  snd_addr  out  AW       fetch address, valid while sload_n=0
//  sload_n   out  1        low for the one clk32 cycle after a granted slot_en
//  snd_ch    out  2        channel owning the current fetch
//  rvalid    in   1        fetch data valid (one cycle)
//  rdata     in   DW       fetch data
//  pop       in   NCH      DAC takes one word from the channel FIFO
//  sdata     out  NCH*DW   per-channel FIFO head
//  sempty    out  NCH      per-channel FIFO empty
//  sundf     out  NCH      sticky underflow: pop while empty
//  stoff     out  NCH      channel stopped at end of a non-repeat frame
//  sint      out  NCH      frame-end interrupt level
//  sint_ack  in   NCH      clears sint (and sundf) of the channel
//  irq       out  1        OR of sint
// BEHAVIOUR
//  - Reset: state IDLE, counters=0, FIFOs empty.
//  - Reset values: sload_n=1, snd_addr=0, snd_ch=0, sint=stoff=sundf=0, sempty=all 1.
//  - Channel FSM, advancing only on slot_en:
//    - IDLE -> RUN when sndon=1; counter <= sfstart, stoff <= 0.
//    - RUN -> IDLE when sndon=0 (checked first): FIFO flushed; any outstanding fetch for it is discarded.
//    - STOP -> IDLE when sndon=0. In STOP, sndon=1 has no effect (needs 0 then 1 to restart).
//  - A channel requests when in RUN and fifo_count + outstanding < FDEPTH (reservation; no overflow possible).
//  - Arbitration on slot_en: round robin from the channel after the last grant.
//    - Grant: snd_addr <= counter, snd_ch <= ch, sload_n <= 0 for exactly one cycle, outstanding <= 1.
//    - No requester: sload_n stays 1.
//  - Counter update on grant:
//    - counter==sfend and sfrep=1: counter <= sfstart; sint <= 1.
//    - counter==sfend and sfrep=0: sint <= 1, stoff <= 1, state STOP; FIFO keeps draining.
//    - otherwise: counter+1, wrapping modulo 2^AW.
//  - sfstart==sfend: one-word frame; end is detected on every fetch.
//  - sfstart/sfrep changes take effect at the next reload; sfend is compared live.
//  - Data return:
//    - rvalid while outstanding: push rdata into the granted channel's FIFO; outstanding <= 0.
//    - rvalid without outstanding: ignored.
//    - rvalid must arrive before the next slot_en; if it has not, that slot grants nothing.
//  - pop: head advances next cycle; sdata shows the head combinationally; sempty follows the FIFO.
//    - pop on empty sets sundf; sdata holds its value.
//    - push and pop in the same cycle are both honoured.
//  - sint_ack for a channel clears sint and sundf. If a set occurs in the same cycle, set wins.
//  - irq is combinational from the registered sint.
//  - porb asserted mid-fetch aborts everything. No partial state survives.
// STRUCTURE
//  - Shared include snd_pkg.vh: FSM state encodings (IDLE/RUN/STOP) and the NCH/ch-index width rule.
//  - Sub-module snd_fifo (DW, FDEPTH; push/pop/count/empty/flush), instantiated once per channel.
//  - Top level holds the channel FSMs, the counters, the arbiter and the outstanding tracker.
// TESTING
//  1. NCH=1, start=0x100, end=0x103, sfrep=0, sndon=1, rvalid 2 clk after each grant, DAC idle.
//     -> snd_addr 0x100..0x103, then no grant; FIFO full at 4; stoff=1, sint=1 after the 4th grant.
//  2. Same, but sfrep=1, DAC pops each time sempty=0.
//     -> addresses 0x100,101,102,103,100,...; sint=1 at each wrap; stoff stays 0.
//  3. NCH=2, both running, FIFOs never full.
//     -> snd_ch alternates 0,1,0,1 on consecutive slot_en.
//  4. sndon[0] dropped while a ch0 fetch is outstanding.
//     -> the returning rdata is discarded; sempty[0]=1; no sint.
//  5. pop[1] on an empty FIFO.
//     -> sundf[1]=1; it stays set until sint_ack[1].
//  6. start=end=0x1FFFFF with sfrep=0.
//     -> a single fetch at 0x1FFFFF, then STOP. With sfrep=1 instead, the counter never wraps to 0.

Source files
------------

// File: rtl/snddma_ctrl_pkg.sv
// Shared definitions for the sound DMA controller: channel FSM encodings
// and the channel-index width rule.
// No ports; imported by snddma_ctrl and snddma_ctrl_fifo.
package snddma_ctrl_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_STOP = 2'd2
  } ch_state_e;

  // A single channel still needs a one-bit index so the arbiter and
  // outstanding tracker keep a uniform shape.
  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/snddma_ctrl_fifo.sv
// Per-channel prefetch FIFO for the sound DMA; head is shown combinationally.
// Latency: push visible on dout/empty the cycle after; pop advances head next cycle.
// Backpressure: none; push while full or pop while empty is ignored, flush wins.
// Ports: clk/rst_n (async active-low), flush, push/din, pop, dout (head),
//        count (words held), empty.
module snddma_ctrl_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != CW'(DEPTH));
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset: an empty FIFO never exposes stale words as valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end

endmodule

// File: rtl/snddma_ctrl.sv
// N-channel sound DMA: per-channel frame walkers, round-robin slot arbiter,
// single outstanding fetch, prefetch FIFO and frame-end interrupt per channel.
// Latency: grant on the slot_en edge, sload_n low the following cycle.
// Backpressure: a channel only requests while its FIFO has room; a slot whose
//   previous fetch has not returned grants nothing.
// Ports: clk32/porb clock and async active-low reset; slot_en bus slot strobe;
//   sndon/sfrep/sfstart/sfend channel config; snd_addr/sload_n/snd_ch fetch
//   request; rvalid/rdata fetch return; pop/sdata/sempty DAC side;
//   sundf/stoff/sint/sint_ack/irq status and interrupt.
module snddma_ctrl
  import snddma_ctrl_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int AW     = 21,
  parameter int DW     = 16,
  parameter int FDEPTH = 4
) (
  input  logic              clk32,
  input  logic              porb,
  input  logic              slot_en,
  input  logic [NCH-1:0]    sndon,
  input  logic [NCH-1:0]    sfrep,
  input  logic [NCH*AW-1:0] sfstart,
  input  logic [NCH*AW-1:0] sfend,
  output logic [AW-1:0]     snd_addr,
  output logic              sload_n,
  output logic [1:0]        snd_ch,
  input  logic              rvalid,
  input  logic [DW-1:0]     rdata,
  input  logic [NCH-1:0]    pop,
  output logic [NCH*DW-1:0] sdata,
  output logic [NCH-1:0]    sempty,
  output logic [NCH-1:0]    sundf,
  output logic [NCH-1:0]    stoff,
  output logic [NCH-1:0]    sint,
  input  logic [NCH-1:0]    sint_ack,
  output logic              irq
);

  localparam int CHW = ch_idx_w(NCH);
  localparam int FCW = $clog2(FDEPTH) + 1;

  ch_state_e                  state [NCH];
  logic [AW-1:0]              cnt   [NCH];
  logic [NCH-1:0][FCW-1:0]    fcnt;

  logic                       outst;     // one fetch in flight
  logic                       drop;      // in-flight fetch belongs to a stopped channel
  logic [CHW-1:0]             out_ch;
  logic [CHW-1:0]             last_gnt;

  logic [NCH-1:0]             req;
  logic [NCH-1:0]             at_end;
  logic [NCH-1:0]             flush;
  logic [NCH-1:0]             push;

  logic                       hi_any;
  logic                       lo_any;
  logic [CHW-1:0]             hi_idx;
  logic [CHW-1:0]             lo_idx;
  logic                       gnt_any;
  logic [CHW-1:0]             gnt_idx;

  // Because only one fetch may be in flight and requests are blocked while
  // it is, the FIFO count alone is the reservation: the returning word
  // always has a free entry.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      at_end[c] = (cnt[c] == sfend[c*AW +: AW]);
      flush[c]  = slot_en && (state[c] == CH_RUN) && !sndon[c];
      push[c]   = rvalid && outst && !drop && (int'(out_ch) == c) && !flush[c];
      req[c]    = (state[c] == CH_RUN) && sndon[c] && !outst &&
                  (fcnt[c] < FCW'(FDEPTH));
    end
  end

  // Round robin: the lowest requester above the last grant wins, otherwise
  // the lowest requester at or below it.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (req[c]) begin
        if (c > int'(last_gnt)) begin
          hi_any = 1'b1;
          hi_idx = CHW'(c);
        end else begin
          lo_any = 1'b1;
          lo_idx = CHW'(c);
        end
      end
    end
    gnt_any = slot_en && (hi_any || lo_any);
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      sload_n  <= 1'b1;
      snd_addr <= '0;
      snd_ch   <= '0;
      outst    <= 1'b0;
      drop     <= 1'b0;
      out_ch   <= '0;
      last_gnt <= '0;
      for (int c = 0; c < NCH; c++) begin
        state[c] <= CH_IDLE;
        cnt[c]   <= '0;
        sint[c]  <= 1'b0;
        stoff[c] <= 1'b0;
        sundf[c] <= 1'b0;
      end
    end else begin
      sload_n <= 1'b1;

      if (rvalid && outst) begin
        outst <= 1'b0;
        drop  <= 1'b0;
      end

      if (gnt_any) begin
        outst    <= 1'b1;
        drop     <= 1'b0;
        out_ch   <= gnt_idx;
        last_gnt <= gnt_idx;
        snd_addr <= cnt[gnt_idx];
        snd_ch   <= 2'(gnt_idx);
        sload_n  <= 1'b0;
      end

      for (int c = 0; c < NCH; c++) begin
        // Set has priority over acknowledge for both sticky flags.
        if (pop[c] && sempty[c])  sundf[c] <= 1'b1;
        else if (sint_ack[c])     sundf[c] <= 1'b0;

        if (gnt_any && (int'(gnt_idx) == c) && at_end[c]) sint[c] <= 1'b1;
        else if (sint_ack[c])                              sint[c] <= 1'b0;

        if (slot_en) begin
          case (state[c])
            CH_IDLE: begin
              if (sndon[c]) begin
                state[c] <= CH_RUN;
                cnt[c]   <= sfstart[c*AW +: AW];
                stoff[c] <= 1'b0;
              end
            end
            CH_RUN: begin
              if (!sndon[c]) begin
                state[c] <= CH_IDLE;
                // Data still on the way for this channel must not land later.
                if (outst && (int'(out_ch) == c) && !rvalid) drop <= 1'b1;
              end else if (gnt_any && (int'(gnt_idx) == c)) begin
                if (at_end[c]) begin
                  if (sfrep[c]) begin
                    cnt[c] <= sfstart[c*AW +: AW];
                  end else begin
                    stoff[c] <= 1'b1;
                    state[c] <= CH_STOP;
                  end
                end else begin
                  cnt[c] <= cnt[c] + AW'(1);
                end
              end
            end
            CH_STOP: begin
              if (!sndon[c]) state[c] <= CH_IDLE;
            end
            default: state[c] <= CH_IDLE;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    snddma_ctrl_fifo #(
      .DW    (DW),
      .DEPTH (FDEPTH)
    ) u_fifo (
      .clk   (clk32),
      .rst_n (porb),
      .flush (flush[g]),
      .push  (push[g]),
      .din   (rdata),
      .pop   (pop[g]),
      .dout  (sdata[g*DW +: DW]),
      .count (fcnt[g]),
      .empty (sempty[g])
    );
  end

  assign irq = |sint;

endmodule
